// File: rtl/riscv_reg_wr_arb.sv
// riscv_reg_wr_arb
// -----------------------------------------------------------------------------
// Write-port controller for the 32x32 RISC-V register file. Once reset is
// released it can zero-fill x1..x31. It then shares the one write port between
// requester A (ALU writeback) and requester B (load/debug writeback), using
// round-robin arbitration.
//
// Ports
//   clk, rst                  clock (rising edge); asynchronous active-high reset
//   a_valid/a_addr/a_data     requester A write request
//   a_ready                   A transfer accepted this cycle (combinational)
//   b_valid/b_addr/b_data     requester B write request
//   b_ready                   B transfer accepted this cycle (combinational)
//   wr_en/wr_addr/wr_data     registered register-file write port
//   busy                      zero-fill sweep in progress
//   state_dbg                 current FSM state (0 = CLEAR, 1 = RUN)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A requester holds addr/data stable from raising valid until that edge.
// ready depends on valid but valid never depends on ready. At most one ready is
// high per cycle. The accepted write reaches the write port one cycle later.
// -----------------------------------------------------------------------------
module riscv_reg_wr_arb #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              state_dbg
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                prio_q, prio_d;      // 0 = A preferred, 1 = B preferred
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
            else                state_q <= ST_RUN;
            clr_idx_q <= FIRST_IDX;
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        prio_d    = prio_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_idx_q;
                wr_data_d = '0;
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                // With CLEAR_ON_RESET=0 the state is already RUN during reset,
                // so ready is also gated by rst to stay low while it is held.
                a_ready = !rst && a_valid && (!b_valid || !prio_q);
                b_ready = !rst && b_valid && (!a_valid ||  prio_q);
                if (a_ready) begin
                    prio_d = 1'b1;
                    // A write to x0 still counts as a grant but never reaches the file.
                    if (a_addr != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = a_addr;
                        wr_data_d = a_data;
                    end
                end else if (b_ready) begin
                    prio_d = 1'b0;
                    if (b_addr != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = b_addr;
                        wr_data_d = b_data;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q == ST_CLEAR);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_riscv_reg_wr_arb.sv
module tb_riscv_reg_wr_arb;

  localparam int DW = 32;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;

  logic          a_ready, b_ready, wr_en, busy, state_dbg;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          a_ready0, b_ready0, wr_en0, busy0, state_dbg0;
  logic [AW-1:0] wr_addr0;
  logic [DW-1:0] wr_data0;

  int total = 0;
  int bad   = 0;

  riscv_reg_wr_arb #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  riscv_reg_wr_arb #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready0), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready0), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .state_dbg(state_dbg0)
  );

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
    total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    total++; if (wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    total++; if ({a_ready, b_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {a_ready, b_ready}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%0b exp=1", busy); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy_noclear got=%0b exp=0", busy0); end
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL release_busy got=%0b exp=1", busy); end
  endtask

  // Sweep from reset release; optionally A raises a request during the sweep.
  task automatic test_sweep(input bit with_req);
    for (int i = 1; i <= 31; i++) begin
      tick();
      total++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== 32'd0) begin
        bad++;
        $display("FAIL sweep_write[%0d] got en=%0b addr=%0d data=%0h exp en=1 addr=%0d data=0",
                 i, wr_en, wr_addr, wr_data, i);
      end
      if (with_req && i == 9) begin
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'd7;
      end
      #1;
      total++;
      if (busy !== (i < 31)) begin bad++; $display("FAIL sweep_busy[%0d] got=%0b exp=%0b", i, busy, (i < 31)); end
      if (with_req && i >= 9) begin
        total++;
        if (a_ready !== (i == 31)) begin
          bad++; $display("FAIL sweep_a_ready[%0d] got=%0b exp=%0b", i, a_ready, (i == 31));
        end
      end
    end
    tick();
    if (with_req) begin
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'd7) begin
        bad++; $display("FAIL held_req_write got en=%0b addr=%0d data=%0d exp en=1 addr=5 data=7", wr_en, wr_addr, wr_data);
      end
      idle_inputs();
      tick();
    end
    total++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sweep_end got en=%0b busy=%0b exp en=0 busy=0", wr_en, busy);
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd69;
    #1;
    total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL single_a_ready got=%b exp=10", {a_ready, b_ready}); end
    tick();
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== 32'd69) begin
      bad++; $display("FAIL single_a_write got en=%0b addr=%0d data=%0d exp en=1 addr=1 data=69", wr_en, wr_addr, wr_data);
    end
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd420;
    #1;
    total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL single_b_ready got=%b exp=01", {a_ready, b_ready}); end
    tick();
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd2 || wr_data !== 32'd420) begin
      bad++; $display("FAIL single_b_write got en=%0b addr=%0d data=%0d exp en=1 addr=2 data=420", wr_en, wr_addr, wr_data);
    end
    idle_inputs();
    tick();
    total++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd2 || wr_data !== 32'd420) begin
      bad++; $display("FAIL idle_hold got en=%0b addr=%0d data=%0d exp en=0 addr=2 data=420", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_b;
    logic [DW-1:0] exp_d;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd101;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd202;
    for (int k = 0; k < 4; k++) begin
      exp_b = k[0];   // A, B, A, B
      #1;
      total++;
      if ({a_ready, b_ready} !== {~exp_b, exp_b}) begin
        bad++; $display("FAIL contend_ready[%0d] got=%b exp=%b", k, {a_ready, b_ready}, {~exp_b, exp_b});
      end
      exp_d = exp_b ? b_data : a_data;
      tick();
      total++;
      if (wr_en !== 1'b1 || wr_addr !== (exp_b ? 5'd4 : 5'd3) || wr_data !== exp_d) begin
        bad++; $display("FAIL contend_write[%0d] got en=%0b addr=%0d data=%0d exp en=1 addr=%0d data=%0d",
                        k, wr_en, wr_addr, wr_data, (exp_b ? 4 : 3), exp_d);
      end
      if (exp_b) b_data = b_data + 32'd1;
      else       a_data = a_data + 32'd1;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b exp=1", a_ready); end
    tick();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL x0_no_write got=%0b exp=0", wr_en); end
    a_addr = 5'd7; a_data = 32'd1;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'd2;
    #1;
    total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL x0_prio_ready got=%b exp=01", {a_ready, b_ready}); end
    tick();
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'd2) begin
      bad++; $display("FAIL x0_prio_write got en=%0b addr=%0d data=%0d exp en=1 addr=8 data=2", wr_en, wr_addr, wr_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'd66;
    tick();
    total++; if (wr_en !== 1'b1 || wr_addr !== 5'd6) begin bad++; $display("FAIL mid_pre got en=%0b addr=%0d exp en=1 addr=6", wr_en, wr_addr); end
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_async_wr_en got=%0b exp=0", wr_en); end
    total++; if (busy !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b/%0b exp=1/0", busy, busy0); end
    tick();
    rst = 1'b0;
    test_sweep(1'b1);
  endtask

  task automatic test_no_clear();
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'd99;
    #1;
    total++; if (a_ready0 !== 1'b0 || wr_en0 !== 1'b0) begin bad++; $display("FAIL nc_in_reset got ready=%0b en=%0b exp 0/0", a_ready0, wr_en0); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (a_ready0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL nc_ready got ready=%0b busy=%0b exp 1/0", a_ready0, busy0); end
    total++; if (a_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL clr_ready got ready=%0b busy=%0b exp 0/1", a_ready, busy); end
    tick();
    total++;
    if (wr_en0 !== 1'b1 || wr_addr0 !== 5'd9 || wr_data0 !== 32'd99) begin
      bad++; $display("FAIL nc_write got en=%0b addr=%0d data=%0d exp en=1 addr=9 data=99", wr_en0, wr_addr0, wr_data0);
    end
    total++; if (wr_en !== 1'b1 || wr_addr !== 5'd1) begin bad++; $display("FAIL clr_first got en=%0b addr=%0d exp en=1 addr=1", wr_en, wr_addr); end
    idle_inputs();
    tick();
  endtask

  // at most one ready per cycle in any state
  always @(negedge clk) begin
    if (a_ready && b_ready) begin
      bad++; $display("FAIL both_ready got=11 exp=not 11 at %0t", $time);
    end
  end

  initial begin
    test_reset();
    test_sweep(1'b0);
    test_single();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    test_no_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_reg_wr_arb.md
Name: riscv_reg_wr_arb

Overview:
- Write-port controller for the 32x32 RISC-V register file (riscv_reg).
- After reset, it sequences a zero-fill sweep of x1..x31.
- It then shares the single write port between two requesters, A (ALU writeback) and B (load/debug writeback), using valid/ready handshakes and round-robin arbitration.
- Its outputs drive the register file's wr_en/wr_addr/wr_data directly.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (2**ADDR_W registers, x0 hardwired zero)
CLEAR_ON_RESET, 1, 1 = run zero-fill sweep after reset; 0 = go straight to RUN

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
a_valid  in  1  requester A has a write pending
a_ready  out  1  A transfer accepted this cycle
a_addr  in  ADDR_W  A destination register
a_data  in  DATA_W  A write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B transfer accepted this cycle
b_addr  in  ADDR_W  B destination register
b_data  in  DATA_W  B write data
wr_en  out  1  register file write enable (registered)
wr_addr  out  ADDR_W  register file write address (registered)
wr_data  out  DATA_W  register file write data (registered)
busy  out  1  zero-fill sweep in progress

Behaviour:
- Reset: one clock `clk`; `rst` is asynchronous and active-high.
  - While rst=1: state=CLEAR if CLEAR_ON_RESET else RUN; clr_idx=1; prio=0 (A preferred).
  - Outputs in reset: wr_en=0, wr_addr=0, wr_data=0, a_ready=b_ready=0, busy=CLEAR_ON_RESET.
- Reset mid-operation: everything clears immediately. A write registered but not yet consumed is dropped (wr_en falls asynchronously). The sweep restarts from x1.
- CLEAR state:
  - a_ready=b_ready=0 and busy=1.
  - Each rising edge loads wr_en=1, wr_addr=clr_idx, wr_data=0, then increments clr_idx.
  - On the edge that loads clr_idx=31, state goes to RUN.
  - The sweep produces exactly 31 consecutive write cycles, addresses 1..31, starting on the first edge after rst falls.
  - Requests are ignored during CLEAR; the requesters hold them (valid stays high).
- RUN state: busy=0.
  - ready is combinational from valid, state and prio:
    - only A valid -> a_ready=1
    - only B valid -> b_ready=1
    - both valid -> the side selected by prio (0=A, 1=B) gets ready=1, the other gets 0
    - at most one ready high per cycle.
  - Transfer = valid & ready at a rising edge. Next cycle: wr_en=1, wr_addr/wr_data = winner's addr/data. Latency is 1 cycle from handshake to the write-port drive.
  - No transfer that cycle -> wr_en=0 next cycle. wr_addr/wr_data hold their last values.
  - prio update: on any transfer, prio is set to point at the non-granted requester (grant A -> prio=1, grant B -> prio=0). With no transfer, prio holds.
  - Under sustained contention the grants strictly alternate A, B, A, B.
- x0 writes: a request with addr=0 is accepted (ready=1) and counts as a grant for prio, but next-cycle wr_en=0. The register file never sees a write to x0.
- Requester rules: once valid is high, addr/data stay stable until the handshake completes. The arbiter does not need to handle valid dropping before ready.
- Throughput: one write per cycle sustained; no bubble between back-to-back grants.
- Same-address writes from A and B on consecutive grants are committed in grant order; the later grant wins.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, no requests -> busy=1 for 31 cycles; wr_en=1 with wr_addr 1,2,...,31 and wr_data=0; then busy=0, wr_en=0.
- A alone after sweep: a_addr=1, a_data=69 -> a_ready=1 same cycle; next cycle wr_en=1, wr_addr=1, wr_data=69. Then B alone: b_addr=2, b_data=420 -> wr_addr=2, wr_data=420.
- Both valid for 4 cycles from prio=0 (A: addr 3 data 101; B: addr 4 data 202, new values each grant) -> grants A, B, A, B; wr_addr 3, 4, 3, 4; never both ready in one cycle.
- A valid with a_addr=0, a_data=0xDEAD -> a_ready=1, next cycle wr_en=0; a following contested cycle grants B (prio advanced).
- Request asserted during CLEAR (a_addr=5, a_data=7 at sweep cycle 10) -> a_ready=0 until sweep ends; accepted on the first RUN cycle; wr_addr=5, wr_data=7 one cycle later.
- rst pulsed while wr_en=1 (addr 6) in RUN -> wr_en drops to 0 without a clock edge; sweep restarts at wr_addr=1 after release. Repeat with CLEAR_ON_RESET=0 -> busy=0 and requests are accepted on the first edge.
